dht_frame_reader: RTL and testbench
===================================

Name: dht_frame_reader

Overview:
- Parametrised single-wire reader for DHT11/DHT22-class sensors.
- Generates the host start pulse, times the sensor response, and decodes NUM_BITS data bits MSB-first.
- Verifies the 8-bit checksum and presents humidity and temperature words with valid/error status.
- Sits between the open-drain pad (tristate built at top level from data_oe) and the display/UART logic.

Parameters:
CLK_HZ, 1000000, system clock frequency; cycles per microsecond = CLK_HZ/1000000 (integer, >=1)
START_LOW_US, 18000, host low pulse width in us
RELEASE_WAIT_US, 40, max us after release for sensor to pull low
TIMEOUT_US, 100, max us of any single sensor low or high phase before error
BIT_THRESH_US, 50, high-phase length above which a bit decodes as 1 (26-28 us = 0, 70 us = 1)
NUM_BITS, 40, data bits per frame (multiple of 8, >=16)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to start a read; ignored while busy
data_in  in  1  raw pad level, asynchronous to clk
data_oe  out  1  1 = drive pad low; 0 = release (pull-up)
busy  out  1  high from accepted start until valid/error pulse
valid  out  1  one-cycle pulse: frame received, checksum good
error  out  1  one-cycle pulse: frame aborted or checksum bad
err_code  out  2  0 none, 1 no response, 2 phase timeout, 3 checksum; held until next start
frame  out  NUM_BITS  raw received bits, first bit at MSB; updated only with valid
hum  out  16  frame[NUM_BITS-1 -: 16], updated with valid
temp  out  16  frame[NUM_BITS-17 -: 16], updated with valid

Behaviour:
- Reset (async, any state): state IDLE, data_oe=0, busy=0, valid=0, error=0, err_code=0, frame/hum/temp=0, counters 0, synchroniser flops 1.
- data_in passes a 2-flop synchroniser; all decisions use the synchronised level s_in (2-cycle latency). Falling/rising edges are detected on s_in.
- One microsecond tick is generated by a prescaler; all phase timers count ticks. Timer widths use $clog2 of the largest limit.
- FSM:
 IDLE: on start -> START_LOW, busy=1, err_code=0, bit count=0.
 START_LOW: data_oe=1 for START_LOW_US ticks -> RELEASE, data_oe=0.
 RELEASE: wait for s_in=0 -> RESP_LOW; after RELEASE_WAIT_US ticks -> ERR code 1.
 RESP_LOW: wait for s_in=1 -> RESP_HIGH; timeout -> ERR code 2.
 RESP_HIGH: wait for s_in=0 -> BIT_LOW; timeout -> ERR 2.
 BIT_LOW: wait for s_in=1 -> BIT_HIGH, clear high timer; timeout -> ERR 2.
 BIT_HIGH: on s_in falling edge shift in (high ticks > BIT_THRESH_US); after NUM_BITS bits -> CHECK, else BIT_LOW; timeout -> ERR 2 (also covers a stuck-high final bit).
 CHECK (1 cycle): sum of the first NUM_BITS/8-1 bytes mod 256 == last byte -> DONE, else ERR code 3.
 DONE: load frame/hum/temp, valid=1 one cycle, busy=0 -> IDLE.
 ERR: error=1 one cycle, busy=0, err_code latched -> IDLE; frame/hum/temp keep previous values.
- start while busy is ignored; start in the same cycle as a valid/error pulse is ignored (state not yet IDLE).
- The final bit's trailing sensor low (end-of-frame, ~50 us) is not checked.
- valid and error are never high together.

Test Plan:
- Reset mid-read: assert rst during BIT_HIGH -> same cycle data_oe=0, busy=0; after release no pulse until next start.
- Good frame (CLK_HZ=1e6, START_LOW_US=100 for sim): after 100 us low, release; sensor model drives 80 us low/80 us high, then bytes 0x37,0x00,0x19,0x00,0x50 (0-bit = 50 us low/27 us high, 1-bit = 50 us low/70 us high) -> valid pulse, hum=0x3700, temp=0x1900, err_code=0.
- Checksum error: same frame with last byte 0x51 -> error pulse, err_code=3, hum/temp unchanged from previous good read.
- No sensor: pad stays high after release -> error pulse RELEASE_WAIT_US+~3 cycles after release, err_code=1.
- Stuck bit: sensor holds high 150 us during bit 12 -> error, err_code=2, data_oe=0.
- start re-pulsed while busy and at the valid cycle -> ignored; exactly one frame and one valid per accepted start.

Source files
------------

// File: rtl/dht_frame_reader.sv
// Single-wire DHT11/DHT22-class frame reader.
// Drives the host start pulse, times the sensor response, shifts in NUM_BITS
// bits MSB-first, then verifies the trailing checksum byte.
// Ports:
//   clk, rst       - clock and asynchronous active-high reset
//   start          - one-cycle read request; ignored unless idle
//   data_in        - raw pad level, asynchronous to clk
//   data_oe        - 1 drives the pad low, 0 releases it to the pull-up
//   busy           - read in progress, drops with the valid/error pulse
//   valid, error   - one-cycle completion pulses (mutually exclusive)
//   err_code       - 0 none, 1 no response, 2 phase timeout, 3 checksum
//   frame/hum/temp - last good frame and its humidity/temperature words
module dht_frame_reader #(
    parameter int unsigned CLK_HZ          = 1000000,
    parameter int unsigned START_LOW_US    = 18000,
    parameter int unsigned RELEASE_WAIT_US = 40,
    parameter int unsigned TIMEOUT_US      = 100,
    parameter int unsigned BIT_THRESH_US   = 50,
    parameter int unsigned NUM_BITS        = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                data_in,
    output logic                data_oe,
    output logic                busy,
    output logic                valid,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [NUM_BITS-1:0] frame,
    output logic [15:0]         hum,
    output logic [15:0]         temp
);

    localparam int unsigned CYC_PER_US = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
    localparam int unsigned PRESC_W    = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam int unsigned LIM_A      = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int unsigned LIM_B      = (RELEASE_WAIT_US > BIT_THRESH_US) ? RELEASE_WAIT_US : BIT_THRESH_US;
    localparam int unsigned MAX_LIM    = (LIM_A > LIM_B) ? LIM_A : LIM_B;
    localparam int unsigned TMR_W      = $clog2(MAX_LIM + 1);
    localparam int unsigned CNT_W      = $clog2(NUM_BITS + 1);
    localparam int unsigned NUM_BYTES  = NUM_BITS / 8;

    typedef enum logic [3:0] {
        IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
        BIT_LOW, BIT_HIGH, CHECK, DONE, ERR
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_q, sync_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic                data_oe_q, data_oe_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [NUM_BITS-1:0] frame_q, frame_d;
    logic [15:0]         hum_q, hum_d;
    logic [15:0]         temp_q, temp_d;

    logic                s_in, s_prev, fall, tick, tmo;
    logic [7:0]          sum;

    assign s_in   = sync_q[1];
    assign s_prev = sync_q[2];
    // Edge-based so the host's own low pulse, still draining out of the
    // synchroniser after release, is not mistaken for a sensor response.
    assign fall   = s_prev & ~s_in;
    assign tick   = (presc_q == PRESC_W'(CYC_PER_US - 1));
    assign tmo    = tick && (tmr_q == TMR_W'(TIMEOUT_US));

    // Checksum: sum of all data bytes except the last, modulo 256
    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(NUM_BYTES) - 1; i++) begin
            sum = sum + shreg_q[NUM_BITS - 1 - 8 * i -: 8];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        sync_d     = {sync_q[1:0], data_in};
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        err_code_d = err_code_q;
        frame_d    = frame_q;
        hum_d      = hum_q;
        temp_d     = temp_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = START_LOW;
                    err_code_d = 2'd0;
                    bitcnt_d   = '0;
                end
            end
            START_LOW: begin
                if (tick && tmr_q == TMR_W'(START_LOW_US - 1)) state_d = RELEASE;
            end
            RELEASE: begin
                if (fall) begin
                    state_d = RESP_LOW;
                end else if (tick && tmr_q == TMR_W'(RELEASE_WAIT_US)) begin
                    state_d    = ERR;
                    err_code_d = 2'd1;
                end
            end
            RESP_LOW: begin
                if (s_in) state_d = RESP_HIGH;
                else if (tmo) begin
                    state_d    = ERR;
                    err_code_d = 2'd2;
                end
            end
            RESP_HIGH: begin
                if (!s_in) state_d = BIT_LOW;
                else if (tmo) begin
                    state_d    = ERR;
                    err_code_d = 2'd2;
                end
            end
            BIT_LOW: begin
                if (s_in) state_d = BIT_HIGH;
                else if (tmo) begin
                    state_d    = ERR;
                    err_code_d = 2'd2;
                end
            end
            BIT_HIGH: begin
                // High-phase length in ticks decides the bit value
                if (fall) begin
                    shreg_d  = {shreg_q[NUM_BITS-2:0], (tmr_q > TMR_W'(BIT_THRESH_US))};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    state_d  = (bitcnt_q == CNT_W'(NUM_BITS - 1)) ? CHECK : BIT_LOW;
                end else if (tmo) begin
                    state_d    = ERR;
                    err_code_d = 2'd2;
                end
            end
            CHECK: begin
                if (sum == shreg_q[7:0]) begin
                    state_d = DONE;
                end else begin
                    state_d    = ERR;
                    err_code_d = 2'd3;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Phase timer restarts on every state change
        if (state_d != state_q || state_q == IDLE) tmr_d = '0;
        else if (tick)                             tmr_d = tmr_q + TMR_W'(1);
        else                                       tmr_d = tmr_q;

        if (state_d == DONE) begin
            frame_d = shreg_q;
            hum_d   = shreg_q[NUM_BITS-1 -: 16];
            temp_d  = shreg_q[NUM_BITS-17 -: 16];
        end

        // Outputs follow the next state so they line up with state_q
        data_oe_d = (state_d == START_LOW);
        busy_d    = state_d inside {START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
                                    BIT_LOW, BIT_HIGH, CHECK};
        valid_d   = (state_d == DONE);
        error_d   = (state_d == ERR);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_q     <= 3'b111;
            presc_q    <= '0;
            tmr_q      <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            frame_q    <= '0;
            hum_q      <= '0;
            temp_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            presc_q    <= presc_d;
            tmr_q      <= tmr_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            frame_q    <= frame_d;
            hum_q      <= hum_d;
            temp_q     <= temp_d;
        end
    end

    assign data_oe  = data_oe_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign frame    = frame_q;
    assign hum      = hum_q;
    assign temp     = temp_q;

endmodule

// File: tb/tb_dht_frame_reader.sv
// Self-checking bench for dht_frame_reader: table of whole frames driven by a
// cycle-level sensor model, plus directed no-response, stuck-bit, start-while-
// busy and reset-mid-read sequences.
module tb_dht_frame_reader;

    localparam int unsigned NB = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sensor;
    logic          data_in;
    logic          data_oe, busy, valid, error;
    logic [1:0]    err_code;
    logic [NB-1:0] frame;
    logic [15:0]   hum, temp;

    // Open-drain pad: host pulls low, otherwise the sensor/pull-up decides
    assign data_in = data_oe ? 1'b0 : sensor;

    always #5 clk = ~clk;

    dht_frame_reader #(
        .CLK_HZ(1000000), .START_LOW_US(100), .RELEASE_WAIT_US(40),
        .TIMEOUT_US(100), .BIT_THRESH_US(50), .NUM_BITS(NB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .data_oe(data_oe), .busy(busy), .valid(valid), .error(error),
        .err_code(err_code), .frame(frame), .hum(hum), .temp(temp)
    );

    typedef struct {
        logic [NB-1:0] bytes;
        logic          exp_valid;
        logic [1:0]    exp_code;
        logic [15:0]   exp_hum;
        logic [15:0]   exp_temp;
    } vec_t;

    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;
    int   vcnt  = 0;
    int   ecnt  = 0;
    int   overlap = 0;
    logic [NB-1:0] last_frame;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) vcnt = vcnt + 1;
            if (error) ecnt = ecnt + 1;
            if (valid && error) overlap = overlap + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        sensor = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Sensor model: waits for the host pulse to end, then answers.
    // no_resp leaves the line high; stop_bit>=0 holds that bit high for
    // stop_hold cycles and returns with the line still high.
    task automatic drive_frame(input logic [NB-1:0] bits, input logic no_resp,
                               input int stop_bit, input int stop_hold);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        sensor = 1'b1;
        while (n < 1000 && !(seen && !data_oe)) begin
            @(negedge clk);
            if (data_oe) seen = 1;
            n++;
        end
        if (n >= 1000) check("host_release", 64'(data_oe), 64'(0));
        if (no_resp) return;
        hold(1'b1, 20);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < int'(NB); i++) begin
            hold(1'b0, 50);
            if (i == stop_bit) begin
                hold(1'b1, stop_hold);
                return;
            end
            hold(1'b1, bits[NB-1-i] ? 70 : 27);
        end
        hold(1'b0, 50);
        sensor = 1'b1;
    endtask

    task automatic wait_pulse(input int v0, input int e0);
        for (int k = 0; k < 300; k++) begin
            if (vcnt != v0 || ecnt != e0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int v0, e0, lat;
        logic [15:0] h0, t0;

        vecs[0] = '{40'h37_00_19_00_50, 1'b1, 2'd0, 16'h3700, 16'h1900};
        vecs[1] = '{40'h37_00_19_00_51, 1'b0, 2'd3, 16'h3700, 16'h1900};
        vecs[2] = '{40'h02_8C_00_FA_88, 1'b1, 2'd0, 16'h028C, 16'h00FA};
        vecs[3] = '{40'hFF_FF_FF_FF_FC, 1'b1, 2'd0, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{40'h00_00_00_00_00, 1'b1, 2'd0, 16'h0000, 16'h0000};
        vecs[5] = '{40'h12_34_56_78_13, 1'b0, 2'd3, 16'h0000, 16'h0000};

        rst = 1'b1; start = 1'b0; sensor = 1'b1;
        last_frame = '0;
        repeat (3) @(negedge clk);
        check("rst_data_oe", 64'(data_oe), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_err_code", 64'(err_code), 64'(0));
        check("rst_frame", 64'(frame), 64'(0));
        check("rst_hum", 64'(hum), 64'(0));
        check("rst_temp", 64'(temp), 64'(0));
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v0 = vcnt; e0 = ecnt;
            pulse_start();
            check("vec_busy_on", 64'(busy), 64'(1));
            drive_frame(vecs[i].bytes, 1'b0, -1, 0);
            wait_pulse(v0, e0);
            if (vecs[i].exp_valid) last_frame = vecs[i].bytes;
            check($sformatf("vec%0d_valid_cnt", i), 64'(vcnt - v0), 64'(vecs[i].exp_valid ? 1 : 0));
            check($sformatf("vec%0d_error_cnt", i), 64'(ecnt - e0), 64'(vecs[i].exp_valid ? 0 : 1));
            check($sformatf("vec%0d_err_code", i), 64'(err_code), 64'(vecs[i].exp_code));
            check($sformatf("vec%0d_hum", i), 64'(hum), 64'(vecs[i].exp_hum));
            check($sformatf("vec%0d_temp", i), 64'(temp), 64'(vecs[i].exp_temp));
            check($sformatf("vec%0d_frame", i), 64'(frame), 64'(last_frame));
            check($sformatf("vec%0d_busy_off", i), 64'(busy), 64'(0));
        end

        // No sensor: error about RELEASE_WAIT_US cycles after release
        v0 = vcnt; e0 = ecnt;
        pulse_start();
        drive_frame('0, 1'b1, -1, 0);
        lat = 0;
        while (lat < 200 && !error) begin
            @(negedge clk);
            lat++;
        end
        check("noresp_latency_ok", 64'((lat >= 40 && lat <= 45) ? 1 : 0), 64'(1));
        check("noresp_err_code", 64'(err_code), 64'(1));
        repeat (5) @(negedge clk);
        check("noresp_error_cnt", 64'(ecnt - e0), 64'(1));
        check("noresp_valid_cnt", 64'(vcnt - v0), 64'(0));

        // Stuck high during bit 12
        v0 = vcnt; e0 = ecnt; h0 = hum; t0 = temp;
        pulse_start();
        drive_frame(vecs[0].bytes, 1'b0, 12, 150);
        wait_pulse(v0, e0);
        check("stuck_error_cnt", 64'(ecnt - e0), 64'(1));
        check("stuck_valid_cnt", 64'(vcnt - v0), 64'(0));
        check("stuck_err_code", 64'(err_code), 64'(2));
        check("stuck_data_oe", 64'(data_oe), 64'(0));
        check("stuck_hum_kept", 64'(hum), 64'(h0));
        check("stuck_temp_kept", 64'(temp), 64'(t0));

        // Start re-pulsed while busy and on the valid cycle
        v0 = vcnt; e0 = ecnt;
        pulse_start();
        fork
            drive_frame(vecs[0].bytes, 1'b0, -1, 0);
            begin
                int k;
                repeat (300) @(negedge clk);
                start = 1'b1; @(negedge clk); start = 1'b0;
                repeat (1500) @(negedge clk);
                start = 1'b1; @(negedge clk); start = 1'b0;
                k = 0;
                while (k < 8000 && !valid) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 8000) check("restart_valid_seen", 64'(valid), 64'(1));
                start = 1'b1; @(negedge clk); start = 1'b0;
            end
        join
        repeat (300) @(negedge clk);
        check("restart_valid_cnt", 64'(vcnt - v0), 64'(1));
        check("restart_error_cnt", 64'(ecnt - e0), 64'(0));
        check("restart_busy", 64'(busy), 64'(0));
        check("restart_data_oe", 64'(data_oe), 64'(0));
        check("restart_hum", 64'(hum), 64'(16'h3700));

        // Reset in the middle of a bit's high phase
        v0 = vcnt; e0 = ecnt;
        pulse_start();
        drive_frame(vecs[2].bytes, 1'b0, 5, 10);
        check("midread_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("midrst_data_oe", 64'(data_oe), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_hum", 64'(hum), 64'(0));
        @(negedge clk) rst = 1'b0;
        sensor = 1'b1;
        repeat (300) @(negedge clk);
        check("midrst_no_valid", 64'(vcnt - v0), 64'(0));
        check("midrst_no_error", 64'(ecnt - e0), 64'(0));
        check("midrst_idle_busy", 64'(busy), 64'(0));

        // Recovery after reset
        v0 = vcnt; e0 = ecnt;
        pulse_start();
        drive_frame(vecs[2].bytes, 1'b0, -1, 0);
        wait_pulse(v0, e0);
        check("recover_valid_cnt", 64'(vcnt - v0), 64'(1));
        check("recover_hum", 64'(hum), 64'(16'h028C));
        check("recover_temp", 64'(temp), 64'(16'h00FA));

        check("valid_error_overlap", 64'(overlap), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
